// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-add multiplier, one multiplier bit per clock.
// Supports signed and unsigned operands. The result is 2*WIDTH bits.
// Uses a four-phase valid/done/acknowledge handshake.
// Optional build macro SEQ_MULT_EARLY_EXIT_EN: CALC ends once the
// remaining multiplier bits are all zero.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | ready; oIdle high once settled, valid accepts operands
// CALC     | add shifted multiplicand when multiplier LSB set, shift
// SIGN     | apply product sign, publish oResult, raise oDone
// DONE     | oDone held until acknowledge is sampled high
// ACK_WAIT | wait for acknowledge to drop before returning to IDLE
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [WIDTH-1:0]     iData_A,
  input  logic [WIDTH-1:0]     iData_B,
  input  logic                 iSigned,
  input  logic                 iValid_Data,
  input  logic                 iAcknoledged,
  output logic                 oDone,
  output logic                 oIdle,
  output logic [2*WIDTH-1:0]   oResult
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    SIGN,
    DONE,
    ACK_WAIT
  } state_t;

  state_t             state;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   mplier_next;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [CNT_W-1:0]   bit_cnt;
  logic               sign_flag;
  logic               a_neg;
  logic               b_neg;
  logic               calc_last;

  // Operand magnitudes straight from the inputs.
  // The most negative value maps to 2^(WIDTH-1) as an unsigned value.
  always_comb begin
    a_neg = iSigned & iData_A[WIDTH-1];
    b_neg = iSigned & iData_B[WIDTH-1];
    a_mag = a_neg ? (~iData_A + WIDTH'(1)) : iData_A;
    b_mag = b_neg ? (~iData_B + WIDTH'(1)) : iData_B;
  end

  // Decide whether the current CALC cycle is the last one.
  always_comb begin
    mplier_next = mplier >> 1;
`ifdef SEQ_MULT_EARLY_EXIT_EN
    calc_last = (bit_cnt == LAST_BIT) || (mplier_next == '0);
`else
    calc_last = (bit_cnt == LAST_BIT);
`endif
  end

  // Sequencing FSM with registered handshake outputs and datapath.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      oDone     <= 1'b0;
      oIdle     <= 1'b0;
      oResult   <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      bit_cnt   <= '0;
      sign_flag <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // oIdle is low for one cycle after reset, so no accept happens before it rises.
          if (oIdle && iValid_Data) begin
            mcand     <= {{WIDTH{1'b0}}, a_mag};
            mplier    <= b_mag;
            acc       <= '0;
            bit_cnt   <= '0;
            sign_flag <= a_neg ^ b_neg;
            oIdle     <= 1'b0;
            state     <= CALC;
          end else begin
            oIdle <= 1'b1;
          end
        end
        CALC: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand   <= mcand << 1;
          mplier  <= mplier_next;
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (calc_last) begin
            state <= SIGN;
          end
        end
        SIGN: begin
          oResult <= sign_flag ? -acc : acc;
          oDone   <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          if (iAcknoledged) begin
            oDone <= 1'b0;
            state <= ACK_WAIT;
          end
        end
        ACK_WAIT: begin
          if (!iAcknoledged) begin
            oIdle <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
